// File: rtl/button_debounce_bank.sv
// button_debounce_bank
//   Synchronises and debounces a bank of raw push-button / switch pins.
//   Each channel is qualified against a shared free-running tick prescaler
//   and yields a clean level plus one-cycle press and release pulses.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   BTN          raw asynchronous button pins (polarity set by ACTIVE_LOW)
//   btn_state    debounced level, 1 = pressed regardless of pin polarity
//   btn_press    one-clk pulse on the edge btn_state rises
//   btn_release  one-clk pulse on the edge btn_state falls
//   any_press    registered OR of btn_press (one cycle behind it)
module button_debounce_bank #(
    parameter int NUM_BTN      = 8,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] BTN,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic               any_press
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS + 1) : 1;

    localparam logic [PW-1:0]      PMAX  = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0]      CLAST = CW'(STABLE_TICKS - 1);
    localparam logic [NUM_BTN-1:0] IDLE  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] lvl;
    logic [PW-1:0]      pcnt;
    logic               tick;
    logic [CW-1:0]      cnt [NUM_BTN];

    // Two-flop synchroniser, reset to the idle pin level so that reset
    // release does not look like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= IDLE;
            sync2 <= IDLE;
        end else begin
            sync1 <= BTN;
            sync2 <= sync1;
        end
    end

    always_comb begin
        lvl = (ACTIVE_LOW != 0) ? ~sync2 : sync2;
    end

    // Free-running prescaler; never restarted by button activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
        end else if (pcnt == PMAX) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        tick = (pcnt == PMAX);
    end

    // Per-channel qualification. Any cycle where the synchronised level
    // matches the accepted state clears the counter, so a single glitch
    // back restarts the whole stable window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_state   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= 1'b0;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            any_press   <= |btn_press;
            for (int unsigned i = 0; i < NUM_BTN; i++) begin
                if (lvl[i] == btn_state[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CLAST) begin
                        btn_state[i]   <= lvl[i];
                        btn_press[i]   <= lvl[i];
                        btn_release[i] <= ~lvl[i];
                        cnt[i]         <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
module tb_button_debounce_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] BTN = 8'hFF;
    logic [7:0] btn_state, btn_press, btn_release;
    logic       any_press;

    logic [7:0] BTN6 = 8'h00;
    logic [7:0] state6, press6, release6;
    logic       any6;

    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    button_debounce_bank #(.NUM_BTN(8), .TICK_DIV(4), .STABLE_TICKS(3), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .BTN(BTN),
        .btn_state(btn_state), .btn_press(btn_press),
        .btn_release(btn_release), .any_press(any_press)
    );

    button_debounce_bank #(.NUM_BTN(8), .TICK_DIV(1), .STABLE_TICKS(1), .ACTIVE_LOW(0)) dut6 (
        .clk(clk), .rst_n(rst_n), .BTN(BTN6),
        .btn_state(state6), .btn_press(press6),
        .btn_release(release6), .any_press(any6)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until btn_state equals want; n = edges taken, -1 on timeout.
    // Pulses must stay quiet until the state changes.
    task automatic wait_state(input logic [7:0] want, input int maxc, output int cnt_out);
        cnt_out = -1;
        for (int c = 1; c <= maxc; c++) begin
            step();
            if (btn_state === want) begin
                cnt_out = c;
                break;
            end
            check("quiet_pulses", {16'h0, btn_press, btn_release}, 32'h0);
        end
    endtask

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_state", {24'h0, btn_state}, 32'h0);
        check("rst_press", {24'h0, btn_press}, 32'h0);
        check("rst_release", {24'h0, btn_release}, 32'h0);
        check("rst_any", {31'h0, any_press}, 32'h0);
        step(); step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("idle_state", {24'h0, btn_state}, 32'h0);
        check("idle_press", {24'h0, btn_press}, 32'h0);

        // 1. Clean press on channel 0
        BTN = 8'hFE;
        wait_state(8'h01, 20, n);
        check("t1_latency_in_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
        check("t1_press", {24'h0, btn_press}, 32'h01);
        check("t1_release", {24'h0, btn_release}, 32'h0);
        check("t1_any_same", {31'h0, any_press}, 32'h0);
        step();
        check("t1_press_end", {24'h0, btn_press}, 32'h0);
        check("t1_any_next", {31'h0, any_press}, 32'h1);
        check("t1_state_hold", {24'h0, btn_state}, 32'h01);
        step();
        check("t1_any_end", {31'h0, any_press}, 32'h0);
        for (int k = 0; k < 20; k++) step();
        check("t1_steady_press", {24'h0, btn_press}, 32'h0);
        check("t1_steady_state", {24'h0, btn_state}, 32'h01);

        // 3. Release of channel 0
        BTN = 8'hFF;
        wait_state(8'h00, 20, n);
        check("t3_latency_in_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
        check("t3_release", {24'h0, btn_release}, 32'h01);
        check("t3_press", {24'h0, btn_press}, 32'h0);
        step();
        check("t3_release_end", {24'h0, btn_release}, 32'h0);
        check("t3_any", {31'h0, any_press}, 32'h0);

        // 2. Bounce rejection on channel 3
        for (int r = 0; r < 5; r++) begin
            BTN = 8'hF7;
            for (int k = 0; k < 6; k++) begin
                step();
                check("t2_bounce_press", {24'h0, btn_press}, 32'h0);
                check("t2_bounce_state", {24'h0, btn_state}, 32'h0);
            end
            BTN = 8'hFF;
            step();
            check("t2_bounce_press", {24'h0, btn_press}, 32'h0);
        end
        BTN = 8'hF7;
        wait_state(8'h08, 20, n);
        check("t2_latency_in_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
        check("t2_press", {24'h0, btn_press}, 32'h08);
        BTN = 8'hFF;
        wait_state(8'h00, 20, n);
        check("t2_release", {24'h0, btn_release}, 32'h08);
        step();

        // 4. All channels simultaneously
        BTN = 8'h00;
        wait_state(8'hFF, 20, n);
        check("t4_latency_in_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
        check("t4_press", {24'h0, btn_press}, 32'hFF);
        step();
        check("t4_press_end", {24'h0, btn_press}, 32'h0);
        check("t4_any", {31'h0, any_press}, 32'h1);
        step();
        check("t4_any_end", {31'h0, any_press}, 32'h0);
        BTN = 8'hFF;
        wait_state(8'h00, 20, n);
        check("t4_release", {24'h0, btn_release}, 32'hFF);
        step();

        // 5. Reset mid-qualification (channel 7 already pressed, 5 qualifying)
        BTN = 8'h7F;
        wait_state(8'h80, 20, n);
        check("t5_ch7_press", {24'h0, btn_press}, 32'h80);
        step();
        BTN = 8'h5F;
        for (int k = 0; k < 10; k++) step();
        check("t5_pre_rst_state", {24'h0, btn_state}, 32'h80);
        rst_n = 1'b0;
        #1;
        check("t5_rst_state", {24'h0, btn_state}, 32'h0);
        check("t5_rst_press", {24'h0, btn_press}, 32'h0);
        check("t5_rst_release", {24'h0, btn_release}, 32'h0);
        check("t5_rst_any", {31'h0, any_press}, 32'h0);
        step(); step(); step();
        rst_n = 1'b1;
        wait_state(8'hA0, 20, n);
        check("t5_latency_in_11_14", {31'h0, (n >= 11 && n <= 14)}, 32'h1);
        check("t5_press", {24'h0, btn_press}, 32'hA0);
        step();
        check("t5_any", {31'h0, any_press}, 32'h1);

        // 6. Degenerate parameters: TICK_DIV=1, STABLE_TICKS=1, active-high
        check("t6_idle_state", {24'h0, state6}, 32'h0);
        BTN6 = 8'h02;
        step();
        check("t6_edge1", {24'h0, press6}, 32'h0);
        step();
        check("t6_edge2", {24'h0, press6}, 32'h0);
        step();
        check("t6_edge3_press", {24'h0, press6}, 32'h02);
        check("t6_edge3_state", {24'h0, state6}, 32'h02);
        step();
        check("t6_edge4_press", {24'h0, press6}, 32'h0);
        check("t6_edge4_any", {31'h0, any6}, 32'h1);
        check("t6_edge4_state", {24'h0, state6}, 32'h02);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
